// File: rtl/simmem_pkg.sv
// Shared defaults and the countdown-slot record for the simmem delayed-release path.
package simmem_pkg;

    localparam int unsigned DefaultIdWidth        = 4;
    localparam int unsigned DefaultDelayWidth     = 8;
    localparam int unsigned DefaultNumSlots       = 16;
    localparam int unsigned DefaultMaxOutstanding = 512;

    typedef struct packed {
        logic                         valid;
        logic [DefaultIdWidth-1:0]    id;
        logic [DefaultDelayWidth-1:0] cnt;
    } delay_slot_t;

    // A zero delay still needs one cycle in a slot before the credit appears.
    function automatic logic [DefaultDelayWidth-1:0] clamp_delay(
        input logic [DefaultDelayWidth-1:0] delay
    );
        return (delay == '0) ? DefaultDelayWidth'(1) : delay;
    endfunction

endpackage

// File: rtl/simmem_delay_releaser_if.sv
// Request and release-report signals between the delay releaser and its neighbours.
interface simmem_delay_releaser_if #(
    parameter int unsigned IDWidth    = simmem_pkg::DefaultIdWidth,
    parameter int unsigned DelayWidth = simmem_pkg::DefaultDelayWidth
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [IDWidth-1:0]      in_id_i;
    logic [DelayWidth-1:0]   in_delay_i;
    logic [2**IDWidth-1:0]   release_en_o;
    logic                    released_valid_i;
    logic [IDWidth-1:0]      released_id_i;
    logic                    err_o;

    modport slave (
        input  in_valid_i, in_id_i, in_delay_i, released_valid_i, released_id_i,
        output in_ready_o, release_en_o, err_o
    );

    modport master (
        output in_valid_i, in_id_i, in_delay_i, released_valid_i, released_id_i,
        input  in_ready_o, release_en_o, err_o
    );
endinterface

// File: rtl/simmem_delay_slot.sv
// One countdown entry: loads {id, delay}, counts down and flags the cycle it expires.
module simmem_delay_slot
    import simmem_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         load_i,
    input  logic [DefaultIdWidth-1:0]    id_i,
    input  logic [DefaultDelayWidth-1:0] delay_i,
    output logic                         busy_o,
    output logic                         expiring_o,
    output logic [DefaultIdWidth-1:0]    id_o
);

    delay_slot_t slot_reg;

    // load_i is only raised for a free slot, so it never races the countdown.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_reg <= '0;
        end else if (load_i) begin
            slot_reg <= '{valid: 1'b1, id: id_i, cnt: clamp_delay(delay_i)};
        end else if (expiring_o) begin
            slot_reg <= '0;
        end else if (slot_reg.valid) begin
            slot_reg.cnt <= slot_reg.cnt - DefaultDelayWidth'(1);
        end
    end

    assign busy_o     = slot_reg.valid;
    assign expiring_o = slot_reg.valid && (slot_reg.cnt == DefaultDelayWidth'(1));
    assign id_o       = slot_reg.id;

endmodule

// File: rtl/simmem_delay_releaser.sv
// Delays each response by a per-request cycle count, then grants per-ID release
// credits to the linked-list bank until the bank reports the responses gone.
module simmem_delay_releaser
    import simmem_pkg::*;
#(
    parameter int unsigned NumSlots       = DefaultNumSlots,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    simmem_delay_releaser_if.slave   io
);

    localparam int unsigned IDWidth  = DefaultIdWidth;
    localparam int unsigned NumIds   = 2**IDWidth;
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam int unsigned SlotIdxW = $clog2(NumSlots);
    localparam int unsigned PopW     = $clog2(NumSlots + 1);

    logic [NumSlots-1:0] slot_busy;
    logic [NumSlots-1:0] slot_expiring;
    logic [NumSlots-1:0] slot_load;
    logic [IDWidth-1:0]  slot_id [NumSlots];

    logic [CntWidth-1:0] expired_reg [NumIds];
    logic [PopW-1:0]     n_expiring  [NumIds];
    logic [CntWidth-1:0] outstanding_reg;
    logic                err_reg;

    logic                free_found;
    logic [SlotIdxW-1:0] alloc_idx;
    logic                accept;
    logic                release_hit;

    always_comb begin
        free_found = 1'b0;
        alloc_idx  = '0;
        for (int s = int'(NumSlots) - 1; s >= 0; s--) begin
            if (!slot_busy[s]) begin
                free_found = 1'b1;
                alloc_idx  = SlotIdxW'(s);
            end
        end
    end

    // Ready looks only at registered state so the bank's release report
    // cannot form a combinational path back to the request side.
    assign io.in_ready_o = free_found && (outstanding_reg < CntWidth'(MaxOutstanding));
    assign accept        = io.in_valid_i && io.in_ready_o;
    assign release_hit   = io.released_valid_i && (expired_reg[io.released_id_i] != '0);

    generate
        for (genvar gi = 0; gi < NumSlots; gi++) begin : g_slot
            assign slot_load[gi] = accept && (alloc_idx == SlotIdxW'(gi));

            simmem_delay_slot u_slot (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .load_i     (slot_load[gi]),
                .id_i       (io.in_id_i),
                .delay_i    (io.in_delay_i),
                .busy_o     (slot_busy[gi]),
                .expiring_o (slot_expiring[gi]),
                .id_o       (slot_id[gi])
            );
        end

        for (genvar gi = 0; gi < NumIds; gi++) begin : g_id
            logic release_dec;

            always_comb begin
                n_expiring[gi] = '0;
                for (int s = 0; s < int'(NumSlots); s++) begin
                    n_expiring[gi] = n_expiring[gi]
                                   + PopW'(slot_expiring[s] && (slot_id[s] == IDWidth'(gi)));
                end
            end

            assign release_dec = release_hit && (io.released_id_i == IDWidth'(gi));

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    expired_reg[gi] <= '0;
                end else begin
                    expired_reg[gi] <= expired_reg[gi] + CntWidth'(n_expiring[gi])
                                     - CntWidth'(release_dec);
                end
            end

            assign io.release_en_o[gi] = (expired_reg[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            case ({accept, release_hit})
                2'b10:   outstanding_reg <= outstanding_reg + CntWidth'(1);
                2'b01:   outstanding_reg <= outstanding_reg - CntWidth'(1);
                default: outstanding_reg <= outstanding_reg;
            endcase
            if (io.released_valid_i && !release_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign io.err_o = err_reg;

endmodule

// File: tb/tb_simmem_delay_releaser.sv
// Randomized and directed bench: a pending-list/credit model predicts outputs
// per edge into a scoreboard queue; a negedge monitor pops and compares.
module tb_simmem_delay_releaser;

    localparam int NumIds   = 16;
    localparam int NumSlots = 16;
    localparam int MaxOut   = 512;

    logic clk    = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk = ~clk;

    simmem_delay_releaser_if #(.IDWidth(4), .DelayWidth(8)) io ();

    simmem_delay_releaser dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .io     (io)
    );

    typedef struct {
        int id;
        int due;
    } pend_t;

    typedef struct {
        logic [15:0] en;
        logic        rdy;
        logic        err;
        int          edge_n;
    } exp_t;

    pend_t pend_q[$];
    int    credit[NumIds];
    bit    m_err;
    int    edge_n = 0;
    exp_t  sb_q[$];
    exp_t  mon_e;
    int    checks = 0;
    int    errors = 0;

    function automatic int outstanding();
        int sum = pend_q.size();
        for (int i = 0; i < NumIds; i++) sum += credit[i];
        return sum;
    endfunction

    function automatic bit model_ready();
        return (pend_q.size() < NumSlots) && (outstanding() < MaxOut);
    endfunction

    function automatic void model_clear();
        pend_q.delete();
        for (int i = 0; i < NumIds; i++) credit[i] = 0;
        m_err = 1'b0;
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.en = '0;
        for (int i = 0; i < NumIds; i++) e.en[i] = (credit[i] != 0);
        e.rdy    = model_ready();
        e.err    = m_err;
        e.edge_n = edge_n;
        sb_q.push_back(e);
    endfunction

    // Applies the inputs present at this edge to the model.
    function automatic void model_edge();
        bit acc;
        bit rel_ok;
        int rid;
        int d;
        acc    = io.in_valid_i && model_ready();
        rid    = int'(io.released_id_i);
        rel_ok = io.released_valid_i && (credit[rid] > 0);
        if (io.released_valid_i && !rel_ok) m_err = 1'b1;
        for (int i = pend_q.size() - 1; i >= 0; i--) begin
            if (pend_q[i].due == edge_n) begin
                credit[pend_q[i].id]++;
                pend_q.delete(i);
            end
        end
        if (acc) begin
            d = int'(io.in_delay_i);
            pend_q.push_back('{id: int'(io.in_id_i), due: edge_n + ((d == 0) ? 1 : d)});
        end
        if (rel_ok) credit[rid]--;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s edge %0d: got %h expected %h", name, edge_n, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("release_en", 32'(io.release_en_o), 32'(mon_e.en));
            chk("in_ready",   32'(io.in_ready_o),   32'(mon_e.rdy));
            chk("err",        32'(io.err_o),        32'(mon_e.err));
            $display("edge %0d en=%h rdy=%0b err=%0b", mon_e.edge_n, io.release_en_o,
                     io.in_ready_o, io.err_o);
        end
    end

    task automatic drive(input bit v, input int id, input int d, input bit rv, input int rid);
        @(negedge clk);
        #1;
        rst_ni              = 1'b1;
        io.in_valid_i       = v;
        io.in_id_i          = 4'(id);
        io.in_delay_i       = 8'(d);
        io.released_valid_i = rv;
        io.released_id_i    = 4'(rid);
        @(posedge clk);
        edge_n++;
        model_edge();
        push_expected();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_ni              = 1'b0;
        io.in_valid_i       = 1'b0;
        io.in_id_i          = '0;
        io.in_delay_i       = '0;
        io.released_valid_i = 1'b0;
        io.released_id_i    = '0;
        model_clear();
        #1;
        chk("async_rst_en",  32'(io.release_en_o), 32'd0);
        chk("async_rst_rdy", 32'(io.in_ready_o),   32'd1);
        chk("async_rst_err", 32'(io.err_o),        32'd0);
        @(posedge clk);
        edge_n++;
        push_expected();
    endtask

    initial begin
        int pick[$];
        int rid;
        io.in_valid_i       = 1'b0;
        io.in_id_i          = '0;
        io.in_delay_i       = '0;
        io.released_valid_i = 1'b0;
        io.released_id_i    = '0;
        model_clear();
        do_reset();

        // Single request id=2 d=3, released later.
        drive(1'b1, 2, 3, 1'b0, 0);
        idle(4);
        drive(1'b0, 0, 0, 1'b1, 2);
        idle(2);

        // Delay 0 behaves as delay 1.
        drive(1'b1, 1, 0, 1'b0, 0);
        idle(2);
        drive(1'b0, 0, 0, 1'b1, 1);
        idle(1);

        // Fill every slot with long delays; keep requesting while full.
        for (int s = 0; s < NumSlots; s++) drive(1'b1, s, 255, 1'b0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 9, 5, 1'b0, 0);
        idle(252);
        for (int s = 0; s < NumSlots; s++) drive(1'b0, 0, 0, 1'b1, s);
        idle(8);
        for (int i = 0; i < NumIds; i++) begin
            while (credit[i] > 0) drive(1'b0, 0, 0, 1'b1, i);
        end

        // Three id=5 requests timed to expire on the same edge.
        drive(1'b1, 5, 3, 1'b0, 0);
        drive(1'b1, 5, 2, 1'b0, 0);
        drive(1'b1, 5, 1, 1'b0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 1'b1, 5);
        idle(1);

        // id=4 expiry coinciding with an id=4 release.
        drive(1'b1, 4, 1, 1'b0, 0);
        idle(1);
        drive(1'b1, 4, 1, 1'b0, 0);
        drive(1'b0, 0, 0, 1'b1, 4);
        idle(1);
        drive(1'b0, 0, 0, 1'b1, 4);
        idle(1);

        // Reset while countdowns are pending; nothing may fire afterwards.
        drive(1'b1, 6, 6, 1'b0, 0);
        drive(1'b1, 3, 4, 1'b0, 0);
        idle(2);
        do_reset();
        idle(10);

        // Release with no credit sets the sticky error.
        drive(1'b0, 0, 0, 1'b1, 7);
        idle(3);

        // Random traffic, mostly releasing IDs that hold credit.
        for (int c = 0; c < 500; c++) begin
            pick.delete();
            for (int i = 0; i < NumIds; i++) if (credit[i] > 0) pick.push_back(i);
            if (pick.size() != 0 && $urandom_range(0, 9) < 8)
                rid = pick[$urandom_range(0, pick.size() - 1)];
            else
                rid = int'($urandom_range(0, NumIds - 1));
            drive(1'(($urandom_range(0, 1))), int'($urandom_range(0, NumIds - 1)),
                  int'($urandom_range(0, 20)), $urandom_range(0, 9) < 4, rid);
        end
        idle(25);

        do_reset();
        idle(3);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
